// File: rtl/search_scheduler_if.sv
// Candidate/result handshake between the search scheduler and the
// XOR/popcount/min-finder datapath.
//   cand_valid     : candidate offer (scheduler -> datapath)
//   cand_ready     : datapath accepts the candidate
//   cand_coords    : [15:8] vertical offset, [7:0] horizontal offset
//   cand_blk_index : index of the block under search
//   res_valid      : min-finder result pulse, one per block
interface search_scheduler_if;
  logic        cand_valid;
  logic        cand_ready;
  logic [15:0] cand_coords;
  logic [15:0] cand_blk_index;
  logic        res_valid;

  modport master (
    output cand_valid,
    output cand_coords,
    output cand_blk_index,
    input  cand_ready,
    input  res_valid
  );

  modport slave (
    input  cand_valid,
    input  cand_coords,
    input  cand_blk_index,
    output cand_ready,
    output res_valid
  );
endinterface

// File: rtl/search_scheduler.sv
// Search scheduler: walks every candidate offset of a search window for each
// block of a job, issuing one candidate per accepted handshake, and limits the
// number of blocks in flight (fully issued, result not yet returned).
// Ports:
//   clk, reset_n : clock (rising edge), asynchronous active-low reset
//   start        : one-cycle job start request (honoured only when idle)
//   num_blks     : blocks in the job, latched on an accepted start
//   cand         : candidate/result handshake (master side)
//   busy         : job in progress
//   done         : one-cycle job-complete pulse
//   res_err      : sticky, result pulse seen with no block outstanding
module search_scheduler #(
  parameter int unsigned blk_w           = 16,
  parameter int unsigned blk_h           = 16,
  parameter int unsigned search_blk_w    = 64,
  parameter int unsigned search_blk_h    = 16,
  parameter int unsigned max_outstanding = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [15:0]         num_blks,
  search_scheduler_if.master  cand,
  output logic                busy,
  output logic                done,
  output logic                res_err
);

  localparam int unsigned NUM_H = search_blk_w - blk_w + 1;
  localparam int unsigned NUM_V = search_blk_h - blk_h + 1;
  localparam int unsigned OW    = $clog2(max_outstanding + 1);

  localparam logic [7:0]    H_LAST  = 8'(NUM_H - 1);
  localparam logic [7:0]    V_LAST  = 8'(NUM_V - 1);
  localparam logic [OW-1:0] MAX_OUT = OW'(max_outstanding);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_CREDIT,
    DRAIN,
    FINISH
  } state_t;

  state_t        state, state_nxt;
  logic [15:0]   num_blks_q;
  logic [15:0]   blk_idx;
  logic [15:0]   blk_idx_inc;
  logic [7:0]    v_pos;
  logic [7:0]    h_pos;
  logic [OW-1:0] outst;
  logic [OW-1:0] outst_nxt;
  logic          err_set;
  logic          accept;
  logic          scan_end;
  logic          blk_done;

  assign cand.cand_coords    = {v_pos, h_pos};
  assign cand.cand_blk_index = blk_idx;

  assign accept      = cand.cand_valid && cand.cand_ready;
  assign scan_end    = (v_pos == V_LAST) && (h_pos == 8'd0);
  assign blk_done    = accept && scan_end;
  assign blk_idx_inc = blk_idx + 16'd1;

  // Block completion and a result in the same cycle cancel out.
  always_comb begin
    outst_nxt = outst;
    err_set   = 1'b0;
    if (blk_done && !cand.res_valid) begin
      outst_nxt = outst + OW'(1);
    end else if (!blk_done && cand.res_valid) begin
      if (outst != '0) outst_nxt = outst - OW'(1);
      else             err_set   = 1'b1;
    end
  end

  // WAIT_CREDIT and DRAIN look at the post-update count, so a returning
  // result releases the FSM on the following cycle.
  always_comb begin
    state_nxt       = state;
    cand.cand_valid = 1'b0;
    done            = 1'b0;
    busy            = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_nxt = (num_blks != 16'd0) ? ISSUE : FINISH;
      end
      ISSUE: begin
        cand.cand_valid = 1'b1;
        if (blk_done) begin
          if (blk_idx_inc == num_blks_q)  state_nxt = DRAIN;
          else if (outst_nxt >= MAX_OUT)  state_nxt = WAIT_CREDIT;
        end
      end
      WAIT_CREDIT: begin
        if (outst_nxt < MAX_OUT) state_nxt = ISSUE;
      end
      DRAIN: begin
        if (outst_nxt == '0) state_nxt = FINISH;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      num_blks_q <= '0;
      blk_idx    <= '0;
      v_pos      <= '0;
      h_pos      <= '0;
      outst      <= '0;
      res_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      outst <= outst_nxt;
      if (state == IDLE && start) begin
        num_blks_q <= num_blks;
        blk_idx    <= '0;
        v_pos      <= '0;
        h_pos      <= H_LAST;
        outst      <= '0;
        res_err    <= 1'b0;
      end else begin
        if (err_set) res_err <= 1'b1;
        if (accept) begin
          if (h_pos == 8'd0) begin
            h_pos <= H_LAST;
            if (v_pos == V_LAST) begin
              v_pos   <= '0;
              blk_idx <= blk_idx_inc;
            end else begin
              v_pos <= v_pos + 8'd1;
            end
          end else begin
            h_pos <= h_pos - 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_search_scheduler.sv
// Self-checking bench for search_scheduler: directed scenarios plus random
// back-pressure and result timing, compared each cycle against a job-level
// reference model (expected candidate list, blocks in flight, error flag).
module tb_search_scheduler;

  localparam int NH   = 49;
  localparam int NV   = 1;
  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] num_blks;
  logic        busy;
  logic        done;
  logic        res_err;

  search_scheduler_if bus ();

  search_scheduler #(
    .blk_w          (16),
    .blk_h          (16),
    .search_blk_w   (64),
    .search_blk_h   (16),
    .max_outstanding(MAXO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .num_blks(num_blks),
    .cand    (bus),
    .busy    (busy),
    .done    (done),
    .res_err (res_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 job running, 2 completion pulse.
  int          m_phase;
  bit          m_held;
  int          m_out;
  bit          m_err;
  int          acc_cnt;
  logic [31:0] m_q[$];

  function automatic bit m_valid();
    return (m_phase == 1) && !m_held && (m_q.size() > 0);
  endfunction

  function automatic void model_reset();
    m_phase = 0;
    m_held  = 0;
    m_out   = 0;
    m_err   = 0;
    m_q.delete();
  endfunction

  function automatic void model_step(input bit s, input int nb, input bit rdy, input bit rv);
    bit          acc;
    bit          bend;
    logic [31:0] e;
    acc  = m_valid() && rdy;
    bend = 0;
    if (acc) begin
      e    = m_q.pop_front();
      bend = (e[15:8] == 8'(NV - 1)) && (e[7:0] == 8'd0);
      acc_cnt++;
    end
    if (bend && !rv) m_out++;
    else if (!bend && rv) begin
      if (m_out > 0) m_out--;
      else           m_err = 1;
    end
    case (m_phase)
      0: if (s) begin
        m_q.delete();
        for (int b = 0; b < nb; b++)
          for (int v = 0; v < NV; v++)
            for (int h = NH - 1; h >= 0; h--)
              m_q.push_back({16'(b), 8'(v), 8'(h)});
        m_err   = 0;
        m_out   = 0;
        m_held  = 0;
        m_phase = (nb != 0) ? 1 : 2;
      end
      1: begin
        if (m_held) begin
          if (m_out < MAXO) m_held = 0;
        end else if (bend && m_q.size() > 0 && m_out >= MAXO) begin
          m_held = 1;
        end else if (m_q.size() == 0 && !bend && m_out == 0) begin
          m_phase = 2;
        end
      end
      default: m_phase = 0;
    endcase
  endfunction

  task automatic check_outputs();
    logic [31:0] e;
    check("cand_valid", 32'(bus.cand_valid), 32'(m_valid()));
    check("busy", 32'(busy), 32'(m_phase != 0));
    check("done", 32'(done), 32'(m_phase == 2));
    check("res_err", 32'(res_err), 32'(m_err));
    if (m_valid()) begin
      e = m_q[0];
      check("cand_blk_index", 32'(bus.cand_blk_index), 32'(e[31:16]));
      check("cand_coords", 32'(bus.cand_coords), 32'(e[15:0]));
    end
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model.
  task automatic tick(input bit s, input int nb, input bit rdy, input bit rv);
    start          = s;
    num_blks       = 16'(nb);
    bus.cand_ready = rdy;
    bus.res_valid  = rv;
    @(negedge clk);
    check_outputs();
    model_step(s, nb, rdy, rv);
    @(posedge clk);
    #1;
  endtask

  // Run to completion; rv_mode 0 returns results immediately, 1 at random.
  task automatic finish_job(input int nb, input int rdy_pct, input int rv_mode, input int budget);
    bit rdy;
    bit rv;
    for (int c = 0; c < budget && m_phase != 0; c++) begin
      rdy = ($urandom_range(99) < rdy_pct);
      rv  = (m_out > 0) && ((rv_mode == 0) || ($urandom_range(3) == 0));
      tick(0, nb, rdy, rv);
    end
    if (m_phase != 0) check("job_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_job(input int nb, input int rdy_pct, input int rv_mode, input int budget);
    int base;
    base = acc_cnt;
    tick(1, nb, 1'b1, 1'b0);
    finish_job(nb, rdy_pct, rv_mode, budget);
    check("accepted_total", 32'(acc_cnt - base), 32'(nb * NH * NV));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base;
    int          c;
    logic [31:0] e;
    logic [31:0] tgt;

    reset_n        = 1'b0;
    start          = 1'b0;
    num_blks       = '0;
    bus.cand_ready = 1'b0;
    bus.res_valid  = 1'b0;
    acc_cnt        = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_cand_valid", 32'(bus.cand_valid), 32'd0);
    check("rst_coords", 32'(bus.cand_coords), 32'd0);
    check("rst_index", 32'(bus.cand_blk_index), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(res_err), 32'd0);
    reset_n = 1'b1;
    repeat (2) tick(0, 0, 0, 0);

    // Single block, full throughput, immediate result.
    run_job(1, 100, 0, 200);
    tick(0, 0, 0, 0);

    // Empty job.
    run_job(0, 100, 0, 10);
    tick(0, 0, 0, 0);

    // Credit limit: two blocks issue, then the third waits for a result.
    base = acc_cnt;
    tick(1, 3, 1, 0);
    for (int i = 0; i < 2 * NH * NV + 4; i++) tick(0, 3, 1, 0);
    check("stall_accepts", 32'(acc_cnt - base), 32'(2 * NH * NV));
    check("stall_cand_valid", 32'(bus.cand_valid), 32'd0);
    tick(0, 3, 1, 1);
    check("credit_resume", 32'(bus.cand_valid), 32'd1);
    check("credit_resume_index", 32'(bus.cand_blk_index), 32'd2);
    check("credit_resume_coords", 32'(bus.cand_coords), 32'h0030);
    finish_job(3, 100, 0, 300);

    // Spurious result while idle sets the sticky error until the next start.
    tick(0, 0, 0, 1);
    repeat (3) tick(0, 0, 0, 0);
    check("err_sticky", 32'(res_err), 32'd1);
    run_job(1, 100, 0, 200);
    check("err_cleared", 32'(res_err), 32'd0);

    // Result coincident with the last candidate of block 0.
    tgt = {16'd0, 8'(NV - 1), 8'd0};
    tick(1, 2, 1, 0);
    c = 0;
    while (m_q.size() > 0 && c < 300) begin
      e = m_q[0];
      tick(0, 2, 1, m_valid() && (e == tgt));
      c++;
    end
    finish_job(2, 100, 0, 50);

    // Random back-pressure and random result timing.
    for (int j = 0; j < 6; j++) run_job($urandom_range(4, 1), 60, 1, 4000);

    // Reset mid-block, then restart.
    tgt = {16'd1, 16'h0010};
    tick(1, 2, 1, 0);
    c = 0;
    while (!(m_valid() && m_q[0] == tgt) && c < 300) begin
      tick(0, 2, 1, m_out > 0);
      c++;
    end
    check("pre_reset_coords", 32'(bus.cand_coords), 32'h0010);
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.cand_valid), 32'd0);
    check("async_rst_coords", 32'(bus.cand_coords), 32'd0);
    check("async_rst_index", 32'(bus.cand_blk_index), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_err", 32'(res_err), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 0);
    tick(1, 1, 1, 0);
    check("restart_index", 32'(bus.cand_blk_index), 32'd0);
    check("restart_coords", 32'(bus.cand_coords), 32'h0030);
    finish_job(1, 100, 0, 200);
    tick(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
